// File: rtl/fifo_frame_writer.sv
// Frames an upstream payload stream into a FIFO. Each frame is written as a header,
// then the payload, then an XOR checksum. The checksum is inverted when the frame was cut at MAXLEN.
module fifo_frame_writer #(
  parameter int            FW     = 8,
  parameter logic [FW-1:0] HDR    = 8'hA5,
  parameter int            MAXLEN = 64
) (
  input  logic          w_clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] in_data,
  input  logic          in_last,
  input  logic          full,
  output logic          wr,
  output logic [FW-1:0] wdata,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          len_err
);

  typedef enum logic [1:0] {IDLE, HEAD, DATA, CSUM} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] csum;
  logic [7:0]    len;
  logic          trunc;
  logic          acc;
  logic          hit_max;
  logic          csum_wr;

  assign acc     = (state == DATA) && in_valid && !full && !rst;
  assign hit_max = (len + 8'd1) == 8'(MAXLEN);
  assign csum_wr = (state == CSUM) && !full && !rst;
  assign busy    = (state != IDLE);

  always_ff @(posedge w_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = HEAD;
      HEAD:    if (!full) state_nxt = DATA;
      DATA:    if (acc && (in_last || hit_max)) state_nxt = CSUM;
      CSUM:    if (!full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the strobes combinationally, so nothing is written in the reset cycle.
  always_comb begin
    wr       = 1'b0;
    in_ready = 1'b0;
    wdata    = in_data;
    if (!rst) begin
      case (state)
        HEAD: begin
          wr    = !full;
          wdata = HDR;
        end
        DATA: begin
          in_ready = !full;
          wr       = in_valid && !full;
        end
        CSUM: begin
          wr    = !full;
          wdata = trunc ? ~csum : csum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      csum      <= '0;
      len       <= '0;
      trunc     <= 1'b0;
      frame_cnt <= '0;
      len_err   <= 1'b0;
    end else if (acc) begin
      csum <= csum ^ in_data;
      len  <= len + 8'd1;
      // A final word landing exactly on MAXLEN ends the frame normally.
      if (hit_max && !in_last) begin
        trunc   <= 1'b1;
        len_err <= 1'b1;
      end
    end else if (csum_wr) begin
      csum      <= '0;
      len       <= '0;
      trunc     <= 1'b0;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer. A scoreboard queue holds the expected FIFO
// words, and each write is popped from it and compared.
module tb_fifo_frame_writer;

  logic        w_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        full = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr, busy, len_err;
  logic [7:0]  wdata;
  logic [15:0] frame_cnt;

  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 w_clk = ~w_clk;

  fifo_frame_writer #(.FW(8), .HDR(8'hA5), .MAXLEN(4)) dut (
    .w_clk(w_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .full(full), .wr(wr), .wdata(wdata),
    .busy(busy), .frame_cnt(frame_cnt), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must be legal and must match the next expected word.
  always @(negedge w_clk) begin
    chk("wr_while_full_or_rst", {31'd0, wr && (full || rst)}, 32'd0);
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_wr", {24'd0, wdata}, 32'hFFFF_FFFF);
      else                   chk("wdata", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic push(input logic [7:0] w);
    exp_q.push_back(w);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge w_clk);
    while (in_ready !== 1'b1 && n < 60) begin @(negedge w_clk); n++; end
    chk("send_timeout", {31'd0, n < 60}, 32'd1);
    @(posedge w_clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin @(negedge w_clk); n++; end
    chk("drain_timeout", {31'd0, n < 60}, 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge w_clk);
    #1;
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    rst = 1'b0;

    // basic frame
    push(8'hA5); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
    drain();
    chk("basic_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("basic_len_err", {31'd0, len_err}, 32'd0);

    // back-pressure for 5 cycles mid-DATA
    push(8'hA5); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
    send(8'h11, 1'b0);
    in_valid = 1'b1; in_data = 8'h22; full = 1'b1;
    repeat (5) begin
      @(negedge w_clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_wr", {31'd0, wr}, 32'd0);
    end
    @(posedge w_clk); #1;
    full = 1'b0;
    send(8'h22, 1'b0); send(8'h33, 1'b1);
    drain();
    chk("bp_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // back-to-back single-word frames
    push(8'hA5); push(8'h7E); push(8'h7E); push(8'hA5); push(8'hFF); push(8'hFF);
    send(8'h7E, 1'b1); send(8'hFF, 1'b1);
    drain();
    chk("b2b_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // full held during CSUM
    push(8'hA5); push(8'h12); push(8'h34); push(8'h26);
    send(8'h12, 1'b0); send(8'h34, 1'b1);
    full = 1'b1;
    repeat (4) begin
      @(negedge w_clk);
      chk("csum_full_wr", {31'd0, wr}, 32'd0);
      chk("csum_full_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge w_clk); #1;
    full = 1'b0;
    @(negedge w_clk);
    chk("csum_release_wr", {31'd0, wr}, 32'd1);
    drain();
    chk("csum_frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // truncation at MAXLEN=4, then words 05/06 open a fresh frame
    push(8'hA5); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'hFB);
    push(8'hA5); push(8'h05); push(8'h06);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge w_clk);
    chk("trunc_q_empty", exp_q.size(), 32'd0);
    chk("trunc_len_err", {31'd0, len_err}, 32'd1);
    chk("trunc_frame_cnt", {16'd0, frame_cnt}, 32'd6);
    chk("trunc_busy", {31'd0, busy}, 32'd1);

    // reset after 2 payload words of the open frame: no checksum written
    @(posedge w_clk); #1;
    rst = 1'b1;
    @(negedge w_clk);
    chk("midrst_wr", {31'd0, wr}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge w_clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst_len_err", {31'd0, len_err}, 32'd0);
    repeat (3) @(negedge w_clk);
    push(8'hA5); push(8'h3C); push(8'h3C);
    send(8'h3C, 1'b1);
    drain();
    chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
